dlx_regs: RTL and testbench

General-purpose register file for the DLX pipeline: 32 registers of 32 bits, two combinational read ports feeding the decode stage operand latches and one synchronous write port driven by write-back. Register R0 is hardwired to zero, per the DLX architecture. A write-through bypass makes a value written in a cycle visible on the read ports in that same cycle.

---
 rtl/dlx_regs.sv | 68 ++++++
 tb/tb_dlx_regs.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dlx_regs.sv
// DLX general-purpose register file: 32 x 32 bits, R0 hardwired to zero,
// two combinational read ports with write-through bypass, one write port.
module dlx_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB,
    input  logic [4:0]  Rs1,
    input  logic [4:0]  Rs2,
    input  logic [4:0]  Rd,
    input  logic [31:0] reg_s,
    output logic [31:0] S1,
    output logic [31:0] S2
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned NREGS  = 32;

    // R0 has no storage; only R1..R31 are implemented.
    logic [DATA_W-1:0] mem [1:NREGS-1];

    logic wr_en;
    logic bypass1;
    logic bypass2;

    // A write happens only outside reset and never to R0.
    assign wr_en = !rst && WB && (Rd != ADDR_W'(0));

    // Bypass is qualified the same way as a write, so a reset cycle never forwards.
    assign bypass1 = wr_en && (Rd == Rs1);
    assign bypass2 = wr_en && (Rd == Rs2);

    // Storage update: reset clears every register and overrides a concurrent write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < int'(NREGS); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[Rd] <= reg_s;
        end
    end

    // Read port 1: zero for R0, then write-through bypass, then storage.
    always_comb begin
        S1 = '0;
        if (Rs1 == ADDR_W'(0)) begin
            S1 = '0;
        end else if (bypass1) begin
            S1 = reg_s;
        end else begin
            S1 = mem[Rs1];
        end
    end

    // Read port 2: same selection, independent address.
    always_comb begin
        S2 = '0;
        if (Rs2 == ADDR_W'(0)) begin
            S2 = '0;
        end else if (bypass2) begin
            S2 = reg_s;
        end else begin
            S2 = mem[Rs2];
        end
    end

endmodule

// File: tb/tb_dlx_regs.sv
// Bench for dlx_regs: directed vector table, back-to-back and X-input
// sequences, then a randomized run against a behavioral register model.
module tb_dlx_regs;

    logic        clk;
    logic        rst;
    logic        WB;
    logic [4:0]  Rs1;
    logic [4:0]  Rs2;
    logic [4:0]  Rd;
    logic [31:0] reg_s;
    logic [31:0] S1;
    logic [31:0] S2;

    dlx_regs dut (
        .clk   (clk),
        .rst   (rst),
        .WB    (WB),
        .Rs1   (Rs1),
        .Rs2   (Rs2),
        .Rd    (Rd),
        .reg_s (reg_s),
        .S1    (S1),
        .S2    (S2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    typedef struct {
        int          tag;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb[$];
    logic [31:0] model [0:31];
    int          total;
    int          bad;

    function automatic vec_t mk(input logic r, input logic w, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] d,
                                input logic [31:0] wd, input logic [31:0] x1,
                                input logic [31:0] x2);
        vec_t v;
        v.rst = r; v.wb = w; v.rs1 = a1; v.rs2 = a2; v.rd = d;
        v.wdata = wd; v.e1 = x1; v.e2 = x2;
        return v;
    endfunction

    task automatic check(input string name, input int tag, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step=%0d got=%h want=%h", name, tag, act, exp);
        end
    endtask

    // Model read with the architectural priority: R0, bypass, storage.
    function automatic logic [31:0] mread(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (!rst && WB && Rd == a) return reg_s;
        return model[a];
    endfunction

    // Commit what the edge about to occur does to the model.
    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (WB && Rd != 5'd0) begin
            model[Rd] = reg_s;
        end
    endtask

    // Drive one cycle's inputs at the falling edge and queue the expectation.
    task automatic drive(input int tag, input logic r, input logic w, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] d, input logic [31:0] wd,
                         input logic [31:0] x1, input logic [31:0] x2);
        exp_t e;
        @(negedge clk);
        rst = r; WB = w; Rs1 = a1; Rs2 = a2; Rd = d; reg_s = wd;
        e.tag = tag; e.e1 = x1; e.e2 = x2;
        sb.push_back(e);
    endtask

    // Sample mid low phase, well before the next rising edge, and compare.
    task automatic sample(input string name);
        exp_t e;
        #2;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s scoreboard empty got=%h want=entry", name, S1);
        end else begin
            e = sb.pop_front();
            check({name, ".S1"}, e.tag, S1, e.e1);
            check({name, ".S2"}, e.tag, S2, e.e2);
        end
        model_edge();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; WB = 1'b0; Rs1 = '0; Rs2 = '0; Rd = '0; reg_s = '0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;

        // Directed table (rst, wb, rs1, rs2, rd, wdata, exp S1, exp S2).
        vecs.push_back(mk(1, 0,  0,  0,  0, 32'd0,        32'd0,      32'd0));
        vecs.push_back(mk(0, 1,  1, 24,  7, 32'd111111,   32'd0,      32'd0));
        vecs.push_back(mk(0, 0,  7,  0,  0, 32'd0,        32'd111111, 32'd0));
        vecs.push_back(mk(0, 1,  7,  0,  3, 32'd222222,   32'd111111, 32'd0));
        vecs.push_back(mk(0, 0,  3,  3,  0, 32'd0,        32'd222222, 32'd222222));
        vecs.push_back(mk(0, 1, 13, 31, 13, 32'd333333,   32'd333333, 32'd0));
        vecs.push_back(mk(0, 0, 13, 13,  0, 32'd0,        32'd333333, 32'd333333));
        vecs.push_back(mk(0, 1,  7,  3,  7, 32'd555555,   32'd555555, 32'd222222));
        vecs.push_back(mk(0, 0,  7,  3,  0, 32'd0,        32'd555555, 32'd222222));
        vecs.push_back(mk(0, 1,  0,  0,  0, 32'hFFFFFFFF, 32'd0,      32'd0));
        vecs.push_back(mk(0, 0,  0,  7,  0, 32'd0,        32'd0,      32'd555555));
        vecs.push_back(mk(0, 0, 10, 10, 10, 32'd444444,   32'd0,      32'd0));
        vecs.push_back(mk(0, 0, 10, 13,  0, 32'd0,        32'd0,      32'd333333));
        vecs.push_back(mk(1, 1,  5,  7,  5, 32'd123,      32'd0,      32'd555555));
        vecs.push_back(mk(0, 0,  5,  7,  0, 32'd0,        32'd0,      32'd0));
        vecs.push_back(mk(0, 0, 13,  3,  0, 32'd0,        32'd0,      32'd0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(i, vecs[i].rst, vecs[i].wb, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
                  vecs[i].wdata, vecs[i].e1, vecs[i].e2);
            sample("table");
        end

        // Back-to-back writes to R20: each cycle forwards its own data, last wins.
        drive(100, 0, 1, 20, 20, 20, 32'hAAAA_0001, 32'hAAAA_0001, 32'hAAAA_0001);
        sample("b2b");
        drive(101, 0, 1, 20, 20, 20, 32'hBBBB_0002, 32'hBBBB_0002, 32'hBBBB_0002);
        sample("b2b");
        drive(102, 0, 0, 20, 31, 0,  32'd0,         32'hBBBB_0002, 32'd0);
        sample("b2b");

        // Unknown address/data with WB=0 must leave state alone.
        drive(103, 0, 0, 20, 0, 5'bxxxxx, 32'hxxxxxxxx, 32'hBBBB_0002, 32'd0);
        sample("xin");
        drive(104, 0, 0, 20, 7, 0, 32'd0, 32'hBBBB_0002, 32'd0);
        sample("xin");

        // Randomized traffic checked against the model.
        for (int n = 0; n < 400; n++) begin
            logic        r;
            logic        w;
            logic [4:0]  a1;
            logic [4:0]  a2;
            logic [4:0]  d;
            logic [31:0] wd;
            r  = ($urandom_range(0, 39) == 0);
            w  = ($urandom_range(0, 3) != 0);
            d  = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
            wd = $urandom;
            @(negedge clk);
            rst = r; WB = w; Rs1 = a1; Rs2 = a2; Rd = d; reg_s = wd;
            begin
                exp_t e;
                e.tag = 1000 + n; e.e1 = mread(a1); e.e2 = mread(a2);
                sb.push_back(e);
            end
            sample("rand");
        end

        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain left=%0d want=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound the run so a stuck bench still reports.
    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
